// File: rtl/regfile_pkg.sv
// Shared widths, types and constants for the CPU register file.
//
// Contents:
//   DATA_W, ADDR_W  register/data width and register index width
//   reg_idx_t       register index type
//   reg_data_t      register data type
//   ZERO_REG        index of the hardwired-zero register
package regfile_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    localparam reg_idx_t ZERO_REG = '0;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port of the register file.
//
// Ports:
//   idx       register index to read
//   regs      flattened view of the whole register array
//   byp_en    a qualified write is in progress this cycle (forwarding builds only)
//   byp_idx   index being written
//   byp_data  data being written
//   data      selected register contents
//
// Index 0 always reads zero, and that rule wins over forwarding.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = regfile_pkg::DATA_W,
    parameter int ADDR_W   = regfile_pkg::ADDR_W,
    parameter int NUM_REGS = 2**ADDR_W
) (
    input  logic [ADDR_W-1:0]                idx,
    input  logic [NUM_REGS-1:0][DATA_W-1:0]  regs,
    input  logic                             byp_en,
    input  logic [ADDR_W-1:0]                byp_idx,
    input  logic [DATA_W-1:0]                byp_data,
    output logic [DATA_W-1:0]                data
);

    always_comb begin
        data = regs[idx];
        if (byp_en && (idx == byp_idx)) begin
            data = byp_data;
        end
        if (idx == ADDR_W'(ZERO_REG)) begin
            data = '0;
        end
    end

endmodule

// File: rtl/register_file.sv
// 32 x 32 general-purpose register file for the single-cycle CPU datapath.
// Two operand read ports, one debug read port, one synchronous write port.
//
// Ports:
//   clk        system clock, state changes on the rising edge
//   startin    synchronous active-high reset, clears every register, beats a write
//   Read1      index for Data1
//   Read2      index for Data2
//   WriteReg   write index; writes to index 0 are dropped
//   WriteData  write data
//   RegWrite   write enable
//   regNo      index for the debug port val
//   Data1      contents of register Read1 (combinational)
//   Data2      contents of register Read2 (combinational)
//   val        contents of register regNo (combinational)
//
// Build option:
//   REGFILE_BYPASS_EN  when defined, a read whose index matches a qualified
//                      write returns WriteData in the same cycle.
module register_file
    import regfile_pkg::*;
#(
    parameter int DATA_W   = regfile_pkg::DATA_W,
    parameter int ADDR_W   = regfile_pkg::ADDR_W,
    parameter int NUM_REGS = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              startin,
    input  logic [ADDR_W-1:0] Read1,
    input  logic [ADDR_W-1:0] Read2,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] regNo,
    output logic [DATA_W-1:0] Data1,
    output logic [DATA_W-1:0] Data2,
    output logic [DATA_W-1:0] val
);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs;
    logic                            byp_en;

    // Per-entry compare rather than an indexed write: an unknown WriteReg
    // never matches, so it cannot disturb stored contents.
    always_ff @(posedge clk) begin
        if (startin) begin
            regs <= '0;
        end else if (RegWrite) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (WriteReg == i[ADDR_W-1:0]) begin
                    regs[i] <= WriteData;
                end
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign byp_en = RegWrite && !startin && (WriteReg != ADDR_W'(ZERO_REG));
`else
    assign byp_en = 1'b0;
`endif

    regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) u_rd1 (
        .idx      (Read1),
        .regs     (regs),
        .byp_en   (byp_en),
        .byp_idx  (WriteReg),
        .byp_data (WriteData),
        .data     (Data1)
    );

    regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) u_rd2 (
        .idx      (Read2),
        .regs     (regs),
        .byp_en   (byp_en),
        .byp_idx  (WriteReg),
        .byp_data (WriteData),
        .data     (Data2)
    );

    regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) u_dbg (
        .idx      (regNo),
        .regs     (regs),
        .byp_en   (byp_en),
        .byp_idx  (WriteReg),
        .byp_data (WriteData),
        .data     (val)
    );

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

    logic        clk;
    logic        startin;
    logic [4:0]  Read1, Read2, WriteReg, regNo;
    logic [31:0] WriteData;
    logic        RegWrite;
    logic [31:0] Data1, Data2, val;

    int tests_run;
    int tests_failed;

    // Reference model: plain array of register contents.
    logic [31:0] model [32];

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    register_file dut (
        .clk       (clk),
        .startin   (startin),
        .Read1     (Read1),
        .Read2     (Read2),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .RegWrite  (RegWrite),
        .regNo     (regNo),
        .Data1     (Data1),
        .Data2     (Data2),
        .val       (val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // What any read port should show right now, given model contents and
    // the inputs currently being driven.
    function automatic logic [31:0] exp_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'h0;
        if (BYPASS && !startin && RegWrite && WriteReg != 5'd0 && WriteReg == idx)
            return WriteData;
        return model[idx];
    endfunction

    // Advance one rising edge, updating the model with the rules first.
    task automatic tick();
        if (startin) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (RegWrite && WriteReg != 5'd0) begin
            model[WriteReg] = WriteData;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        startin = 1'b0; RegWrite = 1'b0; WriteReg = 5'd0; WriteData = 32'h0;
        #1;
    endtask

    task automatic test_reset();
        logic [4:0] idxs [3];
        idxs[0] = 5'd0; idxs[1] = 5'd1; idxs[2] = 5'd31;
        // Reset together with a write: the write must be discarded.
        startin = 1'b1; RegWrite = 1'b1; WriteReg = 5'd1; WriteData = 32'hFFFF_FFFF;
        tick();
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            Read1 = idxs[k]; Read2 = idxs[k]; regNo = idxs[k]; #1;
            tests_run++;
            if (Data1 !== 32'h0 || Data2 !== 32'h0 || val !== 32'h0) begin
                tests_failed++;
                $display("FAIL reset_idx%0d: Data1=%h Data2=%h val=%h required 00000000",
                         idxs[k], Data1, Data2, val);
            end
        end
    endtask

    task automatic test_basic_write();
        WriteReg = 5'd1; WriteData = 32'hAAAA_AAAA; RegWrite = 1'b1;
        tick();
        RegWrite = 1'b0; Read1 = 5'd1; #1;
        tests_run++;
        if (Data1 !== 32'hAAAA_AAAA) begin
            tests_failed++;
            $display("FAIL basic_write: Data1=%h required aaaaaaaa", Data1);
        end
        WriteReg = 5'd2; WriteData = 32'h5555_5555; RegWrite = 1'b1;
        tick();
        RegWrite = 1'b0; Read2 = 5'd2; Read1 = 5'd1; #1;
        tests_run++;
        if (Data2 !== 32'h5555_5555) begin
            tests_failed++;
            $display("FAIL second_write: Data2=%h required 55555555", Data2);
        end
        tests_run++;
        if (Data1 !== 32'hAAAA_AAAA) begin
            tests_failed++;
            $display("FAIL first_kept: Data1=%h required aaaaaaaa", Data1);
        end
    endtask

    task automatic test_debug_port();
        logic [4:0]  idxs [3];
        logic [31:0] exps [3];
        idxs[0] = 5'd1; exps[0] = 32'hAAAA_AAAA;
        idxs[1] = 5'd2; exps[1] = 32'h5555_5555;
        idxs[2] = 5'd0; exps[2] = 32'h0;
        for (int k = 0; k < 3; k++) begin
            regNo = idxs[k]; #1;
            tests_run++;
            if (val !== exps[k]) begin
                tests_failed++;
                $display("FAIL debug_reg%0d: val=%h required %h", idxs[k], val, exps[k]);
            end
        end
    endtask

    task automatic test_zero_reg();
        WriteReg = 5'd0; WriteData = 32'hDEAD_BEEF; RegWrite = 1'b1;
        tick();
        RegWrite = 1'b0; Read1 = 5'd0; #1;
        tests_run++;
        if (Data1 !== 32'h0) begin
            tests_failed++;
            $display("FAIL zero_reg: Data1=%h required 00000000", Data1);
        end
        WriteReg = 5'd3; WriteData = 32'hDEAD_BEEF; RegWrite = 1'b0;
        tick();
        regNo = 5'd3; #1;
        tests_run++;
        if (val !== 32'h0) begin
            tests_failed++;
            $display("FAIL no_we_reg3: val=%h required 00000000", val);
        end
    endtask

    task automatic test_hazard();
        logic [31:0] pre;
        pre = BYPASS ? 32'h1234_5678 : 32'h0;
        Read1 = 5'd4; WriteReg = 5'd4; WriteData = 32'h1234_5678; RegWrite = 1'b1; #1;
        tests_run++;
        if (Data1 !== pre) begin
            tests_failed++;
            $display("FAIL hazard_pre: Data1=%h required %h", Data1, pre);
        end
        tick();
        RegWrite = 1'b0; #1;
        tests_run++;
        if (Data1 !== 32'h1234_5678) begin
            tests_failed++;
            $display("FAIL hazard_post: Data1=%h required 12345678", Data1);
        end
        // Same write under reset: no forwarding, and reg4 ends up cleared.
        startin = 1'b1; RegWrite = 1'b1; WriteData = 32'hCAFE_F00D; #1;
        tests_run++;
        if (Data1 !== 32'h1234_5678) begin
            tests_failed++;
            $display("FAIL reset_no_fwd: Data1=%h required 12345678", Data1);
        end
        tick();
        idle_inputs();
        tests_run++;
        if (Data1 !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_mid: Data1=%h required 00000000", Data1);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            startin   = ($urandom_range(0, 24) == 0);
            RegWrite  = $urandom_range(0, 1);
            WriteReg  = 5'($urandom_range(0, 31));
            WriteData = $urandom;
            Read1     = ($urandom_range(0, 3) == 0) ? WriteReg : 5'($urandom_range(0, 31));
            Read2     = 5'($urandom_range(0, 31));
            regNo     = ($urandom_range(0, 3) == 0) ? WriteReg : 5'($urandom_range(0, 31));
            #1;
            tests_run++;
            if (Data1 !== exp_read(Read1) || Data2 !== exp_read(Read2) || val !== exp_read(regNo)) begin
                tests_failed++;
                $display("FAIL rand_pre c=%0d: Data1=%h/%h Data2=%h/%h val=%h/%h (actual/required)",
                         c, Data1, exp_read(Read1), Data2, exp_read(Read2), val, exp_read(regNo));
            end
            tick();
            startin = 1'b0; RegWrite = 1'b0; #1;
            tests_run++;
            if (Data1 !== exp_read(Read1) || Data2 !== exp_read(Read2) || val !== exp_read(regNo)) begin
                tests_failed++;
                $display("FAIL rand_post c=%0d: Data1=%h/%h Data2=%h/%h val=%h/%h (actual/required)",
                         c, Data1, exp_read(Read1), Data2, exp_read(Read2), val, exp_read(regNo));
            end
        end
        // Final sweep of the whole array through the debug port.
        for (int i = 0; i < 32; i++) begin
            regNo = 5'(i); #1;
            tests_run++;
            if (val !== exp_read(regNo)) begin
                tests_failed++;
                $display("FAIL sweep_reg%0d: val=%h required %h", i, val, exp_read(regNo));
            end
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        startin = 1'b0; RegWrite = 1'b0; WriteReg = 5'd0; WriteData = 32'h0;
        Read1 = 5'd0; Read2 = 5'd0; regNo = 5'd0;
        @(posedge clk);
        #1;
        test_reset();
        test_basic_write();
        test_debug_port();
        test_zero_reg();
        test_hazard();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
